// File: rtl/fwd_hazard_unit_if.sv
// X/M-stage hazard bus between the pipeline datapath and fwd_hazard_unit.
// Optional statistics outputs exist only when FWD_HAZARD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic [31:0]     inst_X;
   logic            valid_X;
   logic [31:0]     inst_M;
   logic            valid_M;
   logic [XLEN-1:0] alu_M;
   logic [XLEN-1:0] dmem_rdata_M;
   logic [XLEN-1:0] rs1_reg;
   logic [XLEN-1:0] rs2_reg;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            DataFwd;
   logic            stall_X;
`ifdef FWD_HAZARD_STATS_EN
   logic [31:0]     stat_fwd_cnt;
   logic [31:0]     stat_stall_cnt;
`endif

   // Pipeline side: supplies instructions/data, consumes forwarding results.
   modport master (
      output inst_X, valid_X, inst_M, valid_M, alu_M, dmem_rdata_M, rs1_reg, rs2_reg,
      input  rs1_fwd, rs2_fwd, DataFwd, stall_X
`ifdef FWD_HAZARD_STATS_EN
      , input stat_fwd_cnt, stat_stall_cnt
`endif
   );

   // Hazard unit side.
   modport slave (
      input  inst_X, valid_X, inst_M, valid_M, alu_M, dmem_rdata_M, rs1_reg, rs2_reg,
      output rs1_fwd, rs2_fwd, DataFwd, stall_X
`ifdef FWD_HAZARD_STATS_EN
      , output stat_fwd_cnt, stat_stall_cnt
`endif
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// RAW hazard resolution for the X-stage instruction: rs1/rs2 forwarding from
// M and a DEPTH-entry retired-writeback history, store-data forwarding from
// DMEM read data, and a one-cycle load-use stall.
// Optional macro FWD_HAZARD_STATS_EN adds saturating forward/stall counters.
module fwd_hazard_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 5
) (
   input logic              clk,
   input logic              rst,
   fwd_hazard_unit_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic DataFwd_REG = 1'b0;
   localparam logic DataFwd_MEM = 1'b1;

   typedef enum logic {RUN, LDSTALL} state_t;
   state_t state;

   logic [AW-1:0]   rd_M, rs1_X, rs2_X;
   logic [6:0]      op_X, op_M;
   logic            m_writer, m_load_wr, m_alu_wr;
   logic            rs1_used, rs2_used, x_store;
   logic            rs1_live, rs2_live;
   logic            rs1_hit, rs2_hit;
   logic [XLEN-1:0] rs1_sel, rs2_sel;
   logic            store_fwd, load_use, stall;

   logic [DEPTH-1:0] hist_v;
   logic [AW-1:0]    hist_rd [DEPTH];
   logic [XLEN-1:0]  hist_d  [DEPTH];

   logic unused_bits;
   assign unused_bits = ^{bus.inst_X[31:25], bus.inst_X[14:7], bus.inst_M[31:15]};

   // Writer decode in M and reader decode in X.
   always_comb begin
      op_M     = bus.inst_M[6:0];
      op_X     = bus.inst_X[6:0];
      rd_M     = bus.inst_M[7 +: AW];
      rs1_X    = bus.inst_X[15 +: AW];
      rs2_X    = bus.inst_X[20 +: AW];
      m_writer = 1'b0;
      case (op_M)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM, OP_LOAD: m_writer = 1'b1;
         OP_SYSTEM: m_writer = (bus.inst_M[14:12] != 3'b000);
         default:   m_writer = 1'b0;
      endcase
      m_writer  = m_writer && bus.valid_M && (rd_M != '0);
      m_load_wr = m_writer && (op_M == OP_LOAD);
      m_alu_wr  = m_writer && (op_M != OP_LOAD);
      rs1_used  = !((op_X == OP_LUI) || (op_X == OP_AUIPC) || (op_X == OP_JAL));
      rs2_used  = (op_X == OP_OP) || (op_X == OP_STORE) || (op_X == OP_BRANCH);
      x_store   = (op_X == OP_STORE);
      rs1_live  = bus.valid_X && rs1_used && (rs1_X != '0);
      rs2_live  = bus.valid_X && rs2_used && (rs2_X != '0);
   end

   // Operand select: M (non-load) beats history, newest history entry first.
   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      rs1_sel = bus.rs1_reg;
      rs2_sel = bus.rs2_reg;
      if (m_alu_wr && (rd_M == rs1_X)) begin
         rs1_hit = 1'b1;
         rs1_sel = bus.alu_M;
      end
      if (m_alu_wr && (rd_M == rs2_X)) begin
         rs2_hit = 1'b1;
         rs2_sel = bus.alu_M;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (!rs1_hit && hist_v[k] && (hist_rd[k] == rs1_X)) begin
            rs1_hit = 1'b1;
            rs1_sel = hist_d[k];
         end
         if (!rs2_hit && hist_v[k] && (hist_rd[k] == rs2_X)) begin
            rs2_hit = 1'b1;
            rs2_sel = hist_d[k];
         end
      end
      store_fwd   = rs2_live && x_store && m_load_wr && (rd_M == rs2_X);
      load_use    = m_load_wr && ((rs1_live && (rd_M == rs1_X)) ||
                                  (rs2_live && !x_store && (rd_M == rs2_X)));
      stall       = (state == RUN) && load_use;
      bus.rs1_fwd = rs1_live ? rs1_sel : bus.rs1_reg;
      bus.rs2_fwd = rs2_live ? rs2_sel : bus.rs2_reg;
      bus.DataFwd = store_fwd ? DataFwd_MEM : DataFwd_REG;
      bus.stall_X = stall;
   end

   // Retired-writeback history: newest at entry0, bubbles shift in on non-writers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_v <= '0;
      end else begin
         hist_v[0]  <= m_writer;
         hist_rd[0] <= rd_M;
         hist_d[0]  <= m_load_wr ? bus.dmem_rdata_M : bus.alu_M;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            hist_v[k]  <= hist_v[k-1];
            hist_rd[k] <= hist_rd[k-1];
            hist_d[k]  <= hist_d[k-1];
         end
      end
   end

   // Load-use FSM: one stall cycle, then the load is visible from entry0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (stall) state <= LDSTALL;
            LDSTALL: state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] fwd_cnt, stall_cnt;
   logic        fwd_any;

   assign fwd_any            = (rs1_live && rs1_hit) || (rs2_live && rs2_hit) || store_fwd;
   assign bus.stat_fwd_cnt   = fwd_cnt;
   assign bus.stat_stall_cnt = stall_cnt;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (fwd_any && (fwd_cnt != '1))   fwd_cnt   <= fwd_cnt + 32'd1;
         if (stall && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (DEPTH=2).
module tb_fwd_hazard_unit;
   localparam logic [31:0] R1 = 32'h1111_1111;
   localparam logic [31:0] R2 = 32'h2222_2222;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fwd_hazard_unit_if #(.XLEN(32)) bus ();

   fwd_hazard_unit #(.XLEN(32), .DEPTH(2), .AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        df;
      logic        st;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
      return {imm, rs1, 3'd0, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1);
      return {12'd0, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] i_sw(input logic [4:0] rs2, rs1);
      return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
   endfunction
   // LUI x9 whose immediate places r in the bits where rs1 would sit.
   function automatic logic [31:0] i_lui_r(input logic [4:0] r);
      return {12'd0, r, 3'd0, 5'd9, 7'b0110111};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out();
      exp_t e;
      #1;
      e = sb.pop_front();
      checks++;
      assert (bus.rs1_fwd === e.rs1) else begin
         errors++;
         $error("FAIL %s rs1_fwd got %h exp %h", e.tag, bus.rs1_fwd, e.rs1);
      end
      checks++;
      assert (bus.rs2_fwd === e.rs2) else begin
         errors++;
         $error("FAIL %s rs2_fwd got %h exp %h", e.tag, bus.rs2_fwd, e.rs2);
      end
      checks++;
      assert (bus.DataFwd === e.df) else begin
         errors++;
         $error("FAIL %s DataFwd got %b exp %b", e.tag, bus.DataFwd, e.df);
      end
      checks++;
      assert (bus.stall_X === e.st) else begin
         errors++;
         $error("FAIL %s stall_X got %b exp %b", e.tag, bus.stall_X, e.st);
      end
   endtask

   task automatic step(input string tag,
                       input logic [31:0] ix, input logic vx,
                       input logic [31:0] im, input logic vm,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic edf, input logic est);
      exp_t e;
      bus.inst_X       = ix;
      bus.valid_X      = vx;
      bus.inst_M       = im;
      bus.valid_M      = vm;
      bus.alu_M        = alu;
      bus.dmem_rdata_M = dm;
      e.tag = tag; e.rs1 = e1; e.rs2 = e2; e.df = edf; e.st = est;
      sb.push_back(e);
      check_out();
   endtask

`ifdef FWD_HAZARD_STATS_EN
   task automatic check_stats_zero(input string tag);
      checks++;
      assert (bus.stat_fwd_cnt === 32'd0) else begin
         errors++;
         $error("FAIL %s stat_fwd_cnt got %h exp 0", tag, bus.stat_fwd_cnt);
      end
      checks++;
      assert (bus.stat_stall_cnt === 32'd0) else begin
         errors++;
         $error("FAIL %s stat_stall_cnt got %h exp 0", tag, bus.stat_stall_cnt);
      end
   endtask
`endif

   initial begin
      bus.inst_X = '0; bus.valid_X = 1'b0; bus.inst_M = '0; bus.valid_M = 1'b0;
      bus.alu_M = '0; bus.dmem_rdata_M = '0; bus.rs1_reg = R1; bus.rs2_reg = R2;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // Empty history: regfile values pass straight through.
      step("reset", i_add(3, 1, 2), 1, 32'd0, 0, 32'd0, 32'd0, R1, R2, 1'b0, 1'b0);
`ifdef FWD_HAZARD_STATS_EN
      check_stats_zero("reset_stats");
`endif
      tick();

      // M writer forwards to rs1.
      bus.rs1_reg = 32'd0;
      step("m_fwd", i_add(3, 1, 2), 1, i_addi(1, 0, 12'd5), 1, 32'd5, 32'd0,
           32'd5, R2, 1'b0, 1'b0);
      tick();                                  // h0={x1,5}
      bus.rs1_reg = R1;

      // Store data from load in M.
      step("st_mem", i_sw(5, 6), 1, i_lw(5, 0), 1, 32'h99, 32'hAAAA,
           R1, R2, 1'b1, 1'b0);
      tick();                                  // h0={x5,AAAA} h1={x1,5}
      step("st_x0", i_sw(5, 6), 1, i_lw(0, 0), 1, 32'h99, 32'hAAAA,
           R1, 32'hAAAA, 1'b0, 1'b0);
      tick();                                  // h0=- h1={x5,AAAA}
      step("drop_out", i_add(3, 1, 5), 1, 32'd0, 0, 32'd0, 32'd0,
           R1, 32'hAAAA, 1'b0, 1'b0);

      // Load-use stall and follow-up from entry0.
      step("lu_stall", i_add(8, 7, 7), 1, i_lw(7, 0), 1, 32'h99, 32'hDEAD,
           R1, R2, 1'b0, 1'b1);
      tick();                                  // h0={x7,DEAD}, LDSTALL
      step("lu_after", i_add(8, 7, 7), 1, i_lw(7, 0), 1, 32'h99, 32'hBEEF,
           32'hDEAD, 32'hDEAD, 1'b0, 1'b0);
      tick();                                  // h0={x7,BEEF} h1={x7,DEAD}, RUN
      step("lu_again", i_add(8, 7, 7), 1, i_lw(7, 0), 1, 32'h99, 32'hBEEF,
           32'hBEEF, 32'hBEEF, 1'b0, 1'b1);
      tick();                                  // LDSTALL
      step("lu_after2", i_add(8, 7, 7), 1, 32'd0, 0, 32'd0, 32'd0,
           32'hBEEF, 32'hBEEF, 1'b0, 1'b0);
      tick();                                  // h0=- h1={x7,BEEF}

      // Bubble in X drives regfile values; build x4 history.
      step("bubble_x", i_add(9, 7, 0), 0, i_addi(4, 0, 12'd1), 1, 32'd1, 32'd0,
           R1, R2, 1'b0, 1'b0);
      tick();                                  // h0={x4,1}
      step("bubble_x2", i_add(9, 4, 0), 0, i_addi(4, 0, 12'd2), 1, 32'd2, 32'd0,
           R1, R2, 1'b0, 1'b0);
      tick();                                  // h0={x4,2} h1={x4,1}
      step("prio_m", i_add(5, 4, 0), 1, i_addi(4, 0, 12'd3), 1, 32'd3, 32'd0,
           32'd3, R2, 1'b0, 1'b0);
      step("prio_e0", i_add(5, 4, 0), 1, i_addi(4, 0, 12'd3), 0, 32'd3, 32'd0,
           32'd2, R2, 1'b0, 1'b0);
      tick();                                  // h0=- h1={x4,2}
      step("prio_e1", i_add(5, 4, 0), 1, 32'd0, 0, 32'd0, 32'd0,
           32'd2, R2, 1'b0, 1'b0);

      // LUI never reads rs1, whatever bits[19:15] hold.
      for (int r = 1; r < 32; r++) begin
         step($sformatf("lui_r%0d", r), i_lui_r(5'(r)), 1, i_lw(5'(r), 0), 1,
              32'h99, 32'h5555, R1, R2, 1'b0, 1'b0);
      end

      // x0 is never forwarded.
      step("x0_read", i_add(3, 0, 0), 1, i_addi(0, 0, 12'h77), 1, 32'h77, 32'd0,
           R1, R2, 1'b0, 1'b0);
      tick();                                  // history empty

      // Reset while in LDSTALL.
      step("rst_lu", i_add(8, 7, 0), 1, i_lw(7, 0), 1, 32'h99, 32'h1234,
           R1, R2, 1'b0, 1'b1);
      tick();                                  // h0={x7,1234}, LDSTALL
      rst = 1'b1;
      step("rst_pre", i_add(8, 7, 0), 1, 32'd0, 0, 32'd0, 32'd0,
           32'h1234, R2, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      step("rst_hist", i_add(8, 7, 0), 1, 32'd0, 0, 32'd0, 32'd0,
           R1, R2, 1'b0, 1'b0);
`ifdef FWD_HAZARD_STATS_EN
      check_stats_zero("rst_stats");
`endif
      step("rst_run", i_add(8, 7, 0), 1, i_lw(7, 0), 1, 32'h99, 32'h1234,
           R1, R2, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
